// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, RV32I opcodes, trap causes and instruction classes
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_TRAP      = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'b00,
        TC_ILLEGAL = 2'b01,
        TC_TIMEOUT = 2'b10
    } trap_cause_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_SYSTEM  = 3'd5,
        CLS_ILLEGAL = 3'd6
    } iclass_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - memory request/acknowledge handshake bundle
interface instr_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational RV32I opcode to instruction-class map
import cpu_pkg::*;

module opcode_classifier (
    input  logic [6:0] opcode_i,
    output iclass_t    iclass_o
);

    // Map each major opcode onto the class the sequencer branches on
    always_comb begin
        iclass_o = CLS_ILLEGAL;
        case (opcode_i)
            OPC_LOAD:                                iclass_o = CLS_LOAD;
            OPC_STORE:                               iclass_o = CLS_STORE;
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC:  iclass_o = CLS_ALU;
            OPC_BRANCH:                              iclass_o = CLS_BRANCH;
            OPC_JAL, OPC_JALR:                       iclass_o = CLS_JUMP;
            OPC_SYSTEM:                              iclass_o = CLS_SYSTEM;
            default:                                 iclass_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle RV32I control sequencer; INSTR_SEQUENCER_PERF_EN adds instret
import cpu_pkg::*;

module instr_sequencer #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] START_PC       = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [6:0]          opcode,
    input  logic                branch_taken,
    instr_sequencer_if.master   mem,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_branch,
    output logic                reg_write,
    output logic [31:0]         pc_reset_val,
    output logic                busy,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state
`ifdef INSTR_SEQUENCER_PERF_EN
    ,
    output logic [31:0]         instret
`endif
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    iclass_t     class_q, class_d, dec_class;
    trap_cause_t cause_q, cause_d;
    logic [7:0]  wait_q, wait_d;
    logic        mem_req_c, mem_we_c;
    logic        timeout_hit;

    opcode_classifier u_classifier (
        .opcode_i (opcode),
        .iclass_o (dec_class)
    );

    // The wait counter already holds the cycles spent so far, so this cycle is the last allowed
    assign timeout_hit = ((wait_q + 8'd1) == TIMEOUT_LIM);

    // State, decoded class, trap cause and wait counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            class_q <= CLS_ALU;
            cause_q <= TC_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and strobe decode; acknowledge wins over timeout in the same cycle
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        cause_d   = cause_q;
        wait_d    = '0;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_branch = 1'b0;
        reg_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ack) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                case (dec_class)
                    CLS_SYSTEM:  state_d = ST_HALT;
                    CLS_ILLEGAL: begin
                        state_d = ST_TRAP;
                        cause_d = TC_ILLEGAL;
                    end
                    default:     state_d = ST_EXECUTE;
                endcase
            end
            ST_EXECUTE: begin
                case (class_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    CLS_BRANCH: begin
                        pc_write  = 1'b1;
                        pc_branch = branch_taken;
                        state_d   = ST_FETCH;
                    end
                    default:             state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                mem_req_c = 1'b1;
                mem_we_c  = (class_q == CLS_STORE);
                if (mem.mem_ack) begin
                    if (class_q == CLS_STORE) begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d  = ST_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_branch = (class_q == CLS_JUMP);
                state_d   = ST_FETCH;
            end
            ST_HALT, ST_TRAP: begin
                state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_we   = mem_we_c;
    assign pc_reset_val = START_PC;
    assign busy         = !(state_q inside {ST_IDLE, ST_HALT, ST_TRAP});
    assign trap         = (state_q == ST_TRAP);
    assign trap_cause   = cause_q;
    assign state        = state_q;

`ifdef INSTR_SEQUENCER_PERF_EN
    logic [31:0] instret_q;

    // Count an instruction as retired whenever control returns to FETCH after executing it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (state_d == ST_FETCH &&
                     (state_q inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK})) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule
